sync_bit_arbiter: RTL and testbench

//  Source-domain controller that shares one single-bit toggle synchronizer channel among NREQ requesters.

---
 rtl/sync_arb_pkg.sv | 28 ++
 rtl/sync_arb_rr_pick.sv | 36 +++
 rtl/sync_bit_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_sync_bit_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_arb_pkg.sv
// Shared definitions for sync_bit_arbiter and its round-robin picker.
// Holds the controller state encoding and a constant clog2 helper that the
// top level uses to check its IDW parameter.
package sync_arb_pkg;

  // Controller states. IDLE arbitrates, SEND flips the channel bit for one
  // cycle, and WAIT_ACK waits for the returned toggle.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } arb_state_e;

  // Ceiling log2. Usable in constant expressions, so the top level can check
  // its index width during elaboration.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_arb_rr_pick.sv
// Combinational round-robin picker for sync_bit_arbiter.
// Starting at ptr and wrapping past NREQ-1, the first set request bit wins.
// Outputs are a one-hot grant, the winner's index and an any-request flag.
module sync_arb_rr_pick
  import sync_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  index,
  output logic            any
);

  // Scan the request vector from ptr upward with wrap; first hit wins.
  always_comb begin
    int pos_v;
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos_v = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos_v = (int'(ptr) + i) % NREQ;
      if (!any && req[pos_v]) begin
        any          = 1'b1;
        grant[pos_v] = 1'b1;
        index        = IDW'(pos_v);
      end else begin
        index = index;
      end
    end
  end

endmodule

// File: rtl/sync_bit_arbiter.sv
// sync_bit_arbiter: source-side controller sharing one single-bit toggle
// synchronizer channel among NREQ requesters.
//
// One requester is granted at a time (round robin). The controller flips the
// channel bit through sEN/sD_IN, waits for the returned ack toggle, pulses
// done to the granted requester and then arbitrates again. The forward
// synchronizer must be instantiated with init=0 so that both channel bits
// start equal; the destination and reverse synchronizers must share RST_N.
//
// sD_IN carries the value last launched: it changes only together with the
// rising sEN, so it is stable whenever sEN is low.
//
// Optional feature macro: SYNC_ARB_TIMEOUT_EN
//   Adds a TMO_W-bit watchdog on WAIT_ACK. When it expires without an ack,
//   tmo_err pulses, the local toggle realigns to ack_tog, no done is given
//   and the pointer advances. An ack in the expiry cycle takes precedence.
//   Without the macro WAIT_ACK waits indefinitely and tmo_err is tied low.
module sync_bit_arbiter
  import sync_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int TMO_W = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NREQ-1:0] req,
  input  logic            ack_tog,
  output logic            sEN,
  output logic            sD_IN,
  output logic [IDW-1:0]  chan_id,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            tmo_err
);

  // Parameter sanity checks, evaluated at elaboration.
  if (IDW != clog2(NREQ)) begin : g_chk_idw
    $error("sync_bit_arbiter: IDW must equal clog2(NREQ)");
  end
  if ((NREQ < 2) || (NREQ > 16)) begin : g_chk_nreq
    $error("sync_bit_arbiter: NREQ must lie in 2..16");
  end
  if (TMO_W < 1) begin : g_chk_tmo
    $error("sync_bit_arbiter: TMO_W must be at least 1");
  end

  arb_state_e      state_q, state_d;
  logic            tog_q, tog_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  chan_id_q, chan_id_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            sen_q, sen_d;
  logic            sd_q, sd_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] pick_grant_s;
  logic [IDW-1:0]  pick_idx_s;
  logic            pick_any_s;
  logic [IDW-1:0]  next_ptr_s;
  logic            ack_match_s;
  logic            tmo_hit_s;

  sync_arb_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant_s),
    .index (pick_idx_s),
    .any   (pick_any_s)
  );

  assign ack_match_s = (ack_tog == tog_q);

  // Pointer for the next arbitration: one past the current channel, wrapping.
  always_comb begin
    if (chan_id_q == IDW'(NREQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = chan_id_q + IDW'(1);
    end
  end

  // Transfer sequencing: next state and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    tog_d     = tog_q;
    ptr_d     = ptr_q;
    chan_id_d = chan_id_q;
    grant_d   = grant_q;
    sen_d     = 1'b0;
    sd_d      = sd_q;
    done_d    = '0;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          grant_d   = pick_grant_s;
          chan_id_d = pick_idx_s;
          sen_d     = 1'b1;
          sd_d      = ~tog_q;
          busy_d    = 1'b1;
          state_d   = ST_SEND;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        tog_d   = ~tog_q;
        busy_d  = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_match_s) begin
          // grant_q is one-hot on chan_id, so it is exactly done[chan_id].
          done_d  = grant_q;
          ptr_d   = next_ptr_s;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (tmo_hit_s) begin
          // Give up on this transfer and realign the channel bits.
          tog_d   = ack_tog;
          ptr_d   = next_ptr_s;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state and registered outputs; RST_N clears them at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      tog_q     <= 1'b0;
      ptr_q     <= '0;
      chan_id_q <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      sen_q     <= 1'b0;
      sd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tog_q     <= tog_d;
      ptr_q     <= ptr_d;
      chan_id_q <= chan_id_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      sen_q     <= sen_d;
      sd_q      <= sd_d;
      busy_q    <= busy_d;
    end
  end

`ifdef SYNC_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  assign tmo_hit_s = &cnt_q;

  // Watchdog: cleared in SEND, counts WAIT_ACK cycles, fires at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    if (state_q == ST_SEND) begin
      cnt_d = '0;
    end else if (state_q == ST_WAIT_ACK) begin
      cnt_d = cnt_q + TMO_W'(1);
      if (!ack_match_s && tmo_hit_s) begin
        tmo_d = 1'b1;
      end else begin
        tmo_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter and timeout pulse registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign tmo_err = tmo_q;
`else
  assign tmo_hit_s = 1'b0;
  assign tmo_err   = 1'b0;
`endif

  assign sEN     = sen_q;
  assign sD_IN   = sd_q;
  assign chan_id = chan_id_q;
  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sync_bit_arbiter.sv
// Self-checking bench for sync_bit_arbiter (NREQ=4, IDW=2, TMO_W=4).
// Directed cycle table, hand-written corner sequences, and a randomized run
// scored against a transaction-level reference model.
module tb_sync_bit_arbiter;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int TMO_W = 4;

  logic            CLK;
  logic            RST_N;
  logic [NREQ-1:0] req;
  logic            ack_tog;
  logic            sEN;
  logic            sD_IN;
  logic [IDW-1:0]  chan_id;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] done;
  logic            busy;
  logic            tmo_err;

  int n_tests;
  int n_fail;

  // Automatic ack responder: returns sD_IN on ack_tog ack_dly cycles after sEN.
  bit auto_ack;
  int ack_dly;
  int ack_cnt;

  typedef struct packed {
    logic [3:0] req;
    logic       ack;
    logic       sen;
    logic       sd;
    logic [1:0] ch;
    logic [3:0] gr;
    logic [3:0] dn;
    logic       bz;
  } vec_t;
  vec_t tbl [15];

  sync_bit_arbiter #(.NREQ(NREQ), .IDW(IDW), .TMO_W(TMO_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .ack_tog(ack_tog),
    .sEN(sEN), .sD_IN(sD_IN), .chan_id(chan_id), .grant(grant),
    .done(done), .busy(busy), .tmo_err(tmo_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [13:0] outs_now();
    return {sEN, sD_IN, chan_id, grant, done, busy, tmo_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge, then run the ack responder.
  task automatic cycle();
    @(negedge CLK);
    if (auto_ack) begin
      if (sEN) begin
        ack_cnt = ack_dly;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) ack_tog = sD_IN;
      end
    end
  endtask

  task automatic do_reset();
    RST_N    = 1'b0;
    req      = '0;
    ack_tog  = 1'b0;
    auto_ack = 1'b0;
    ack_cnt  = 0;
    cycle();
    cycle();
    RST_N = 1'b1;
  endtask

  // Wait (bounded) for sEN or for any done bit.
  task automatic wait_for(input string name, input bit want_done);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 60) begin
      cycle();
      n++;
      hit = want_done ? (done != '0) : sEN;
    end
    check({name, "_seen"}, 32'(hit), 32'd1);
  endtask

  // Reference round robin: first set bit at or after p, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  initial begin
    int n_done, n_sen, n_tmo, first_ev;
    int m_phase, m_ptr, m_chan;
    logic m_tog, m_sd, e_sen, ack_prev;
    logic [3:0] e_done, e_grant, req_prev;

    n_tests = 0;
    n_fail  = 0;
    ack_dly = 2;

    //          req      ack   sen   sd    ch     grant    done     busy
    tbl[0]  = {4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b1};
    tbl[1]  = {4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b1};
    tbl[2]  = {4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b1};
    tbl[3]  = {4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b1};
    tbl[4]  = {4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b1};
    tbl[5]  = {4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0100, 1'b0};
    tbl[6]  = {4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0};
    tbl[7]  = {4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = {4'b1001, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1000, 4'b0000, 1'b1};
    tbl[9]  = {4'b1001, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1000, 4'b0000, 1'b1};
    tbl[10] = {4'b1001, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b1000, 1'b0};
    tbl[11] = {4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b1};
    tbl[12] = {4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b1};
    tbl[13] = {4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0001, 1'b0};
    tbl[14] = {4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0};

    // Reset state, then the cycle table (single request, ptr=3, wrap to 0).
    do_reset();
    check("reset_state", 32'(outs_now()), 32'd0);
    for (int r = 0; r < 15; r++) begin
      req     = tbl[r].req;
      ack_tog = tbl[r].ack;
      cycle();
      check($sformatf("table_row%0d", r), 32'(outs_now()),
            32'({tbl[r].sen, tbl[r].sd, tbl[r].ch, tbl[r].gr, tbl[r].dn, tbl[r].bz, 1'b0}));
    end

    // All four requesting continuously: strict rotation, alternating toggle.
    do_reset();
    auto_ack = 1'b1;
    ack_dly  = 2;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_for("rot_sen", 1'b0);
      check("rot_chan", 32'(chan_id), 32'(k % 4));
      check("rot_grant", 32'(grant), 32'(1 << (k % 4)));
      check("rot_sd", 32'(sD_IN), (k % 2 == 0) ? 32'd1 : 32'd0);
      wait_for("rot_done", 1'b1);
      check("rot_done", 32'(done), 32'(1 << (k % 4)));
    end

    // Request withdrawn during WAIT_ACK: transfer completes, no re-grant.
    do_reset();
    req = 4'b0001;
    wait_for("drop_sen", 1'b0);
    cycle();
    req = 4'b0000;
    cycle();
    cycle();
    ack_tog = sD_IN;
    n_done = 0;
    n_sen  = 0;
    for (int n = 0; n < 8; n++) begin
      cycle();
      if (done != '0) begin
        n_done++;
        check("drop_done_val", 32'(done), 32'd1);
      end
      if (sEN) n_sen++;
    end
    check("drop_done_count", 32'(n_done), 32'd1);
    check("drop_no_regrant", 32'(n_sen), 32'd0);

    // Asynchronous reset in WAIT_ACK, then a normal transfer.
    do_reset();
    req = 4'b0010;
    wait_for("rst_sen", 1'b0);
    cycle();
    check("rst_busy_before", 32'(busy), 32'd1);
    #2 RST_N = 1'b0;
    #1 check("rst_async_clear", 32'(outs_now()), 32'd0);
    req = 4'b0000;
    cycle();
    RST_N = 1'b1;
    req = 4'b0010;
    wait_for("rst_next_sen", 1'b0);
    check("rst_next_out", 32'(outs_now()), 32'({1'b1, 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b1, 1'b0}));
    cycle();
    ack_tog = 1'b1;
    wait_for("rst_next_done", 1'b1);
    check("rst_next_done", 32'(done), 32'(4'b0010));
    req = 4'b0000;

    // Ack toggling while idle has no effect.
    cycle();
    ack_tog = ~ack_tog;
    for (int n = 0; n < 3; n++) begin
      cycle();
      check("idle_ack_quiet", 32'(outs_now()), 32'({1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0, 1'b0}));
    end

`ifdef SYNC_ARB_TIMEOUT_EN
    // Ack never returns: tmo_err once, no done, channel realigned.
    do_reset();
    req = 4'b0001;
    wait_for("tmo_sen", 1'b0);
    req = 4'b0000;
    n_tmo = 0;
    n_done = 0;
    first_ev = -1;
    for (int n = 1; n <= 30; n++) begin
      cycle();
      if (tmo_err) begin
        n_tmo++;
        if (first_ev < 0) first_ev = n;
      end
      if (done != '0) n_done++;
    end
    check("tmo_cycle", 32'(first_ev), 32'd17);
    check("tmo_width", 32'(n_tmo), 32'd1);
    check("tmo_no_done", 32'(n_done), 32'd0);
    req = 4'b0010;
    wait_for("tmo_next_sen", 1'b0);
    check("tmo_realigned", 32'(outs_now()), 32'({1'b1, 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b1, 1'b0}));
    cycle();
    req = 4'b0000;
    ack_tog = sD_IN;
    wait_for("tmo_next_done", 1'b1);
    check("tmo_next_done", 32'(done), 32'(4'b0010));

    // Ack in the expiry cycle wins over the timeout.
    do_reset();
    req = 4'b0001;
    wait_for("race_sen", 1'b0);
    req = 4'b0000;
    n_tmo = 0;
    first_ev = -1;
    for (int n = 1; n <= 30; n++) begin
      cycle();
      if (tmo_err) n_tmo++;
      if ((done != '0) && (first_ev < 0)) first_ev = n;
      if (n == 16) ack_tog = sD_IN;
    end
    check("race_done_cycle", 32'(first_ev), 32'd17);
    check("race_no_tmo", 32'(n_tmo), 32'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    auto_ack = 1'b1;
    m_phase = 0;
    m_ptr   = 0;
    m_chan  = 0;
    m_tog   = 1'b0;
    m_sd    = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      req_prev = req;
      ack_prev = ack_tog;
      ack_dly  = int'($urandom_range(1, 5));
      cycle();
      e_sen  = 1'b0;
      e_done = 4'b0000;
      if (m_phase == 0) begin
        if (req_prev != 4'b0000) begin
          m_chan  = rr_pick(req_prev, m_ptr);
          m_sd    = ~m_tog;
          e_sen   = 1'b1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_tog   = ~m_tog;
        m_phase = 2;
      end else if (ack_prev == m_tog) begin
        e_done  = 4'(1 << m_chan);
        m_ptr   = (m_chan + 1) % NREQ;
        m_phase = 0;
      end
      e_grant = (m_phase != 0) ? 4'(1 << m_chan) : 4'b0000;
      check("random", 32'(outs_now()),
            32'({e_sen, m_sd, 2'(m_chan), e_grant, e_done, (m_phase != 0), 1'b0}));
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) req[i] = 1'b0;
        else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if ($urandom_range(0, 47) == 0) req[i] = 1'b0;
      end
      if (!busy && ($urandom_range(0, 63) == 0)) ack_tog = ~ack_tog;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
